param_pattern_detector: RTL and testbench
=========================================

// Module: param_pattern_detector
// PURPOSE
//  Serial bit-stream detector with a run-time programmable pattern of 1..MAX_LEN bits.
//  Selectable overlapping or non-overlapping match mode, and a saturating match counter.
//  Successor to the fixed dynamic pattern detector; sits on a valid-qualified serial data path.
//  Downstream logic consumes a one-cycle flag per match plus a running count.
// PARAMETERS
//  MAX_LEN  8   maximum pattern length in bits (>=2)
//  CNT_W    16  width of match_count
//  LEN_W    $clog2(MAX_LEN+1)  localparam, width of cfg_len
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        asynchronous reset, active-low (asserted when 0)
//  cfg_we       in   1        load cfg_pattern/cfg_len/cfg_overlap this cycle
//  cfg_pattern  in   MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
//  cfg_len      in   LEN_W    pattern length; legal range 1..MAX_LEN
//  cfg_overlap  in   1        1 = overlapping matches, 0 = non-overlapping
//  cnt_clr      in   1        synchronous clear of match_count
//  d_in         in   1        serial data bit
//  valid_in     in   1        d_in is sampled only when 1
//  pattern_flag out  1        one-cycle pulse per match
//  match_count  out  CNT_W    saturating count of matches
//  cfg_err      out  1        one-cycle pulse: rejected configuration
//  armed        out  1        1 when a legal pattern is loaded (state ARMED)
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0; state=IDLE; pattern, len, overlap, history and fill are 0.
//  States
//   - IDLE: no legal pattern is loaded; valid_in is ignored.
//   - ARMED: searching for the pattern.
//  Config: on cfg_we with cfg_len in 1..MAX_LEN
//   - latch pattern, len and overlap; clear history and fill; go to ARMED next cycle.
//  Illegal config: cfg_len==0 or >MAX_LEN
//   - pulse cfg_err for one cycle; keep the previous config and state.
//  cfg_we together with valid_in: the config wins and that data bit is dropped (all cases).
//  Datapath, ARMED and valid_in=1 (cfg_we=0):
//   - hist <= {hist[MAX_LEN-2:0], d_in}
//   - fill <= min(fill+1, MAX_LEN)
//   - match = (fill_next >= len) && (hist_next[len-1:0] == pattern[len-1:0])
//  Latency: pattern_flag is registered. It is high in the cycle after the clock edge that
//   samples the final pattern bit.
//  pattern_flag is high for exactly one cycle per match and is never held across cycles.
//  Overlap=1: fill is not cleared on a match (e.g. "11" in 111 gives 2 matches).
//  Overlap=0: a match zeroes fill, so the next match needs len fresh bits.
//  valid_in=0: history, fill and flag are held (flag forced 0); valid gaps do not break a match.
//  match_count
//   - +1 on each match, saturates at all-ones.
//   - cnt_clr has priority over an increment in the same cycle (count becomes 0).
//   - Not cleared by a reconfiguration.
//  Reset asserted mid-stream: everything clears immediately; re-config is required to re-arm.
//  len=1: every valid bit equal to pattern[0] matches, in both modes.
// TESTING
//  1. Reset, then cfg len=4, pattern=4'b1011, overlap=1; stream 1,0,1,1,0,1,1
//     -> flags after bits 4 and 7; match_count=2.
//  2. Same pattern with overlap=0, same stream -> one flag (bit 4); match_count=1.
//  3. len=2, pattern=2'b11; stream 1,1,1,1
//     -> overlap=1 gives 3 flags; overlap=0 gives 2 flags.
//  4. cfg_len=0, or MAX_LEN+1 -> cfg_err pulses once; armed and the previous pattern unchanged.
//     cfg_we with valid_in=1 -> that bit is not counted.
//  5. Pattern 1011 with valid_in=0 gaps inserted between the bits -> a flag still fires.
//     CNT_W=2 driven with 5 matches -> match_count stays 3.
//     cnt_clr together with a match -> match_count=0.
//  6. Drop reset after bit 3 of 1011 -> outputs 0, armed=0.
//     Further d_in ignored until a config write.

Source files
------------

// File: rtl/param_pattern_detector.sv
// Serial bit-stream detector with a run-time programmable pattern of 1..MAX_LEN bits,
// overlapping/non-overlapping match modes and a saturating match counter.
module param_pattern_detector #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 16,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    input  logic               d_in,
    input  logic               valid_in,
    output logic               pattern_flag,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               armed
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    state_t state, state_next;

    logic [MAX_LEN-1:0] pattern_r;
    logic [LEN_W-1:0]   len_r;
    logic               overlap_r;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    logic               cfg_legal;
    logic               cfg_ok;
    logic               sample;
    logic [MAX_LEN-1:0] hist_next;
    logic [LEN_W-1:0]   fill_next;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cfg_legal  = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
        cfg_ok     = cfg_we && cfg_legal;
        if (cfg_ok) begin
            state_next = ARMED;
        end
    end

    // A config write always steals the cycle, so the data bit alongside it is dropped.
    always_comb begin
        sample    = (state == ARMED) && valid_in && !cfg_we;
        hist_next = {hist[MAX_LEN-2:0], d_in};
        fill_next = (fill == MAX_LEN_L) ? fill : fill + 1'b1;
        len_mask  = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len_r)) begin
                len_mask[i] = 1'b1;
            end
        end
        match = sample && (fill_next >= len_r) &&
                (((hist_next ^ pattern_r) & len_mask) == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_r <= '0;
            len_r     <= '0;
            overlap_r <= 1'b0;
            hist      <= '0;
            fill      <= '0;
        end else if (cfg_ok) begin
            pattern_r <= cfg_pattern;
            len_r     <= cfg_len;
            overlap_r <= cfg_overlap;
            hist      <= '0;
            fill      <= '0;
        end else if (sample) begin
            hist <= hist_next;
            // Non-overlapping mode demands len fresh bits after every match.
            fill <= (match && !overlap_r) ? '0 : fill_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_flag <= 1'b0;
            cfg_err      <= 1'b0;
            match_count  <= '0;
        end else begin
            pattern_flag <= match;
            cfg_err      <= cfg_we && !cfg_legal;
            if (cnt_clr) begin
                match_count <= '0;
            end else if (match && (match_count != '1)) begin
                match_count <= match_count + 1'b1;
            end
        end
    end

    assign armed = (state == ARMED);

endmodule

// File: tb/tb_param_pattern_detector.sv
// Randomized scoreboard bench for param_pattern_detector; a second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_param_pattern_detector;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               clk;
    logic               reset;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               d_in;
    logic               valid_in;
    logic               pattern_flag;
    logic [15:0]        match_count;
    logic               cfg_err;
    logic               armed;
    logic               flag2;
    logic [1:0]         count2;
    logic               err2;
    logic               armed2;

    param_pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .d_in(d_in), .valid_in(valid_in), .pattern_flag(pattern_flag),
        .match_count(match_count), .cfg_err(cfg_err), .armed(armed)
    );

    param_pattern_detector #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .d_in(d_in), .valid_in(valid_in), .pattern_flag(flag2),
        .match_count(count2), .cfg_err(err2), .armed(armed2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        flag;
        logic        err;
        logic        armed;
        logic [15:0] count;
        logic [1:0]  count2;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: received bits kept as a queue, matched against the pattern directly.
    logic               m_armed;
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    logic               m_ovl;
    logic               bq[$];
    int                 m_count;
    int                 m_count2;

    function automatic void model_reset();
        m_armed  = 1'b0;
        m_pat    = '0;
        m_len    = 0;
        m_ovl    = 1'b0;
        bq.delete();
        m_count  = 0;
        m_count2 = 0;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic [MAX_LEN-1:0] pat,
                                  input logic [LEN_W-1:0] len, input logic ovl,
                                  input logic clr, input logic d, input logic v);
        exp_t e;
        logic hit;
        @(negedge clk);
        cfg_we      = we;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cnt_clr     = clr;
        d_in        = d;
        valid_in    = v;
        hit = 1'b0;
        e.err = 1'b0;
        if (we) begin
            if (len >= 1 && int'(len) <= MAX_LEN) begin
                m_pat   = pat;
                m_len   = int'(len);
                m_ovl   = ovl;
                m_armed = 1'b1;
                bq.delete();
            end else begin
                e.err = 1'b1;
            end
        end else if (m_armed && v) begin
            bq.push_back(d);
            if (bq.size() > MAX_LEN) void'(bq.pop_front());
            if (bq.size() >= m_len) begin
                hit = 1'b1;
                for (int k = 0; k < m_len; k++) begin
                    if (bq[bq.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 1'b0;
                end
            end
            if (hit && !m_ovl) bq.delete();
        end
        if (clr) begin
            m_count  = 0;
            m_count2 = 0;
        end else if (hit) begin
            if (m_count < 65535) m_count++;
            if (m_count2 < 3) m_count2++;
        end
        e.flag   = hit;
        e.armed  = m_armed;
        e.count  = 16'(m_count);
        e.count2 = 2'(m_count2);
        exp_q.push_back(e);
    endtask

    task automatic cfg(input logic [MAX_LEN-1:0] pat, input int len, input logic ovl, input logic clr);
        apply_stimulus(1'b1, pat, LEN_W'(len), ovl, clr, 1'b0, 1'b0);
    endtask

    task automatic send_bit(input logic d);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, d, 1'b1);
    endtask

    task automatic gap();
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic stream_1011011();
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        send_bit(0); send_bit(1); send_bit(1);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every clock edge that follows an issued stimulus has one expected record.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("pattern_flag", 32'(pattern_flag), 32'(e.flag));
                check_output("cfg_err", 32'(cfg_err), 32'(e.err));
                check_output("armed", 32'(armed), 32'(e.armed));
                check_output("match_count", 32'(match_count), 32'(e.count));
                check_output("match_count_sat", 32'(count2), 32'(e.count2));
                check_output("pattern_flag_sat", 32'(flag2), 32'(e.flag));
            end
        end
    end

    initial begin
        logic [MAX_LEN-1:0] rpat;
        int                 rlen;
        int                 r;
        model_reset();
        reset = 1'b0;
        cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        cnt_clr = 1'b0; d_in = 1'b0; valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_flag", 32'(pattern_flag), 0);
        check_output("reset_count", 32'(match_count), 0);
        check_output("reset_err", 32'(cfg_err), 0);
        check_output("reset_armed", 32'(armed), 0);
        @(negedge clk);
        reset = 1'b1;

        // Idle detector ignores data until configured.
        send_bit(1); send_bit(1);

        cfg(8'b1011, 4, 1'b1, 1'b1);
        stream_1011011();
        settle();
        check_output("t1_overlap_count", 32'(match_count), 2);

        cfg(8'b1011, 4, 1'b0, 1'b1);
        stream_1011011();
        settle();
        check_output("t2_nonoverlap_count", 32'(match_count), 1);

        cfg(8'b11, 2, 1'b1, 1'b1);
        send_bit(1); send_bit(1); send_bit(1); send_bit(1);
        settle();
        check_output("t3_overlap_11", 32'(match_count), 3);
        cfg(8'b11, 2, 1'b0, 1'b1);
        send_bit(1); send_bit(1); send_bit(1); send_bit(1);
        settle();
        check_output("t3_nonoverlap_11", 32'(match_count), 2);

        cfg(8'b1011, 4, 1'b1, 1'b1);
        cfg(8'hFF, 0, 1'b0, 1'b0);
        cfg(8'hFF, MAX_LEN + 1, 1'b0, 1'b0);
        settle();
        check_output("t4_armed_kept", 32'(armed), 1);
        apply_stimulus(1'b1, 8'b1011, LEN_W'(4), 1'b1, 1'b0, 1'b1, 1'b1);
        send_bit(0); send_bit(1); send_bit(1);
        settle();
        check_output("t4_dropped_bit", 32'(match_count), 0);
        send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        settle();
        check_output("t4_old_pattern", 32'(match_count), 1);

        cfg(8'b1011, 4, 1'b1, 1'b1);
        send_bit(1); gap(); send_bit(0); gap(); gap(); send_bit(1); gap(); send_bit(1);
        settle();
        check_output("t5_gaps", 32'(match_count), 1);
        cfg(8'b1, 1, 1'b0, 1'b1);
        repeat (5) send_bit(1);
        settle();
        check_output("t5_sat", 32'(count2), 3);
        check_output("t5_len1", 32'(match_count), 5);
        apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        settle();
        check_output("t5_clr_priority", 32'(match_count), 0);

        cfg(8'b1011, 4, 1'b1, 1'b1);
        send_bit(1); send_bit(0); send_bit(1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check_output("t6_flag", 32'(pattern_flag), 0);
        check_output("t6_count", 32'(match_count), 0);
        check_output("t6_armed", 32'(armed), 0);
        @(negedge clk);
        reset = 1'b1;
        send_bit(1); send_bit(1); send_bit(0); send_bit(1); send_bit(1);
        settle();
        check_output("t6_idle_count", 32'(match_count), 0);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                rpat = MAX_LEN'($urandom);
                if (r < 2) rlen = $urandom_range(1, ($urandom_range(0, 3) == 0) ? MAX_LEN : 3);
                else       rlen = $urandom_range(0, (1 << LEN_W) - 1);
                apply_stimulus(1'b1, rpat, LEN_W'(rlen), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                               1'($urandom), 1'($urandom));
            end else if (r < 5) begin
                apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'($urandom), 1'($urandom));
            end else begin
                apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'($urandom),
                               1'($urandom_range(0, 3) != 0));
            end
        end

        repeat (2) @(posedge clk);
        #2;
        check_output("queue_drain", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
